// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, streams sequential imem reads into a small
// fetch FIFO, and flushes wrong-path words on redirects. Define IF_PERF_CNT_EN for perf counters.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        id_jmp_vld,
  input  logic [31:0] id_jmp_addr,
  input  logic        ex_jmp_vld,
  input  logic [31:0] ex_jmp_addr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int          AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam int          OW      = CW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            req_q;
  logic [31:0]     req_pc_q;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     last_pc_q;
  logic [31:0]     inst_mem_q [FIFO_DEPTH];
  logic [31:0]     pc_mem_q   [FIFO_DEPTH];

  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            redirect;
  logic [31:0]     target_raw;
  logic [31:0]     target;
  logic [OW-1:0]   occ;

  always_comb begin
    fifo_empty = (cnt_q == '0);
    pop        = !fifo_empty && id_ready;
    redirect   = ex_jmp_vld || (id_jmp_vld && pop);
    target_raw = ex_jmp_vld ? ex_jmp_addr : id_jmp_addr;
    target     = {target_raw[31:2], 2'b00};
    // The response already on the bus still needs a slot, so it counts against capacity.
    occ        = {1'b0, cnt_q} - OW'(pop) + OW'(req_q);
    imem_req   = (state_q != S_BOOT) && (occ < DEPTH_W);
    imem_addr  = pc_q;
    // S_DROP's response and any response landing in a redirect cycle are wrong-path.
    push       = imem_rvalid && (state_q == S_RUN) && !redirect;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN,
      S_DROP: begin
        if (redirect) begin
          state_d = imem_req ? S_DROP : S_RUN;
          pc_d    = target;
        end else begin
          state_d = S_RUN;
          if (imem_req) pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Stage boundary: control state, PC and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      last_pc_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= imem_req;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      if (!fifo_empty) last_pc_q <= pc_mem_q[rd_ptr_q];
    end
  end

  // Stage boundary: request address capture and FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (imem_req) req_pc_q <= pc_q;
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  always_comb begin
    if_valid = !fifo_empty;
    if_inst  = fifo_empty ? NOP : inst_mem_q[rd_ptr_q];
    if_pc    = fifo_empty ? last_pc_q : pc_mem_q[rd_ptr_q];
  end

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic        rsp_drop;
  logic [31:0] flush_inc;
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_comb begin
    rsp_drop  = imem_rvalid && ((state_q == S_DROP) || ((state_q == S_RUN) && redirect));
    flush_inc = (redirect ? (32'(cnt_q) - 32'(pop)) : 32'd0) + 32'(rsp_drop);
  end

  // Stage boundary: performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= sat_add(fetch_cnt_q, 32'(pop));
      flush_cnt_q <= sat_add(flush_cnt_q, flush_inc);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: memory returns the address as data, one cycle after each request.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        id_jmp_vld;
  logic [31:0] id_jmp_addr;
  logic        ex_jmp_vld;
  logic [31:0] ex_jmp_addr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .id_jmp_vld (id_jmp_vld),
    .id_jmp_addr(id_jmp_addr),
    .ex_jmp_vld (ex_jmp_vld),
    .ex_jmp_addr(ex_jmp_addr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: fixed 1-cycle latency, data word equals its address.
  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= imem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_ready = 1'b1;
    id_jmp_vld = 1'b0; id_jmp_addr = 32'h0;
    ex_jmp_vld = 1'b0; ex_jmp_addr = 32'h0;
    step(); step();
    settle();
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_addr",  imem_addr,     32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_inst",  if_inst,       32'h0000_0013);
    chk("rst_pc",    if_pc,         32'h0);

    // cycle 0: BOOT
    rst = 1'b0;
    settle();
    chk("boot_req", 32'(imem_req), 32'h0);
    step(); settle(); // cycle 1
    chk("c1_req",   32'(imem_req), 32'h1);
    chk("c1_addr",  imem_addr,     32'h0);
    chk("c1_valid", 32'(if_valid), 32'h0);
    step(); settle(); // cycle 2
    chk("c2_valid", 32'(if_valid), 32'h0);
    chk("c2_addr",  imem_addr,     32'h4);
    step(); settle(); // cycle 3
    chk("c3_valid", 32'(if_valid), 32'h1);
    chk("c3_pc",    if_pc,         32'h0);
    chk("c3_inst",  if_inst,       32'h0);
    step(); settle(); // cycle 4
    chk("c4_pc",    if_pc,         32'h4);

    // cycle 5: JAL from decode on the handshake of pc 0x8
    step();
    id_jmp_vld = 1'b1; id_jmp_addr = 32'h100;
    settle();
    chk("jal_pc",   if_pc,         32'h8);
    chk("jal_req",  32'(imem_req), 32'h1);
    chk("jal_addr", imem_addr,     32'h10);
    step(); // cycle 6
    id_jmp_vld = 1'b0;
    settle();
    chk("jal_c6_valid", 32'(if_valid), 32'h0);
    chk("jal_c6_addr",  imem_addr,     32'h100);
    step(); settle(); // cycle 7
    chk("jal_c7_valid", 32'(if_valid), 32'h0);
    chk("jal_c7_hold",  if_pc,         32'h8);
    step(); settle(); // cycle 8
    chk("jal_tgt_valid", 32'(if_valid), 32'h1);
    chk("jal_tgt_pc",    if_pc,         32'h100);
    chk("jal_tgt_inst",  if_inst,       32'h100);

    // cycle 9: execute and decode redirect together, execute wins
    step();
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'h200;
    id_jmp_vld = 1'b1; id_jmp_addr = 32'h100;
    settle();
    chk("both_pc", if_pc, 32'h104);
    step(); // cycle 10
    ex_jmp_vld = 1'b0; id_jmp_vld = 1'b0;
    settle();
    chk("both_req",  32'(imem_req), 32'h1);
    chk("both_addr", imem_addr,     32'h200);
    step(); settle(); // cycle 11
    chk("both_c11_valid", 32'(if_valid), 32'h0);
    step(); settle(); // cycle 12
    chk("both_tgt_pc", if_pc, 32'h200);

    // cycles 13-17: stall, ignored decode jump, misaligned execute redirect while idle
    step();
    id_ready = 1'b0;
    settle();
    chk("st_pc",  if_pc,         32'h204);
    chk("st_req", 32'(imem_req), 32'h0);
    step(); // cycle 14
    id_jmp_vld = 1'b1; id_jmp_addr = 32'h400;
    settle();
    chk("nohs_valid", 32'(if_valid), 32'h1);
    chk("nohs_req",   32'(imem_req), 32'h0);
    step(); // cycle 15
    id_jmp_vld = 1'b0;
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'h303;
    settle();
    chk("nohs_ignored_valid", 32'(if_valid), 32'h1);
    chk("nohs_ignored_pc",    if_pc,         32'h204);
    chk("ex_idle_req",        32'(imem_req), 32'h0);
    step(); // cycle 16
    ex_jmp_vld = 1'b0; id_ready = 1'b1;
    settle();
    chk("mis_req",   32'(imem_req), 32'h1);
    chk("mis_addr",  imem_addr,     32'h300);
    chk("mis_valid", 32'(if_valid), 32'h0);
    step(); settle(); // cycle 17
    chk("mis_c17_valid", 32'(if_valid), 32'h0);
    chk("mis_c17_hold",  if_pc,         32'h204);

    // cycles 18-22: PC wrap-around
    step();
    ex_jmp_vld = 1'b1; ex_jmp_addr = 32'hFFFF_FFF8;
    settle();
    chk("mis_tgt_pc", if_pc, 32'h300);
    step(); // cycle 19
    ex_jmp_vld = 1'b0;
    settle();
    chk("wrap_c19_addr", imem_addr, 32'hFFFF_FFF8);
    step(); settle(); // cycle 20
    chk("wrap_c20_valid", 32'(if_valid), 32'h0);
    step(); settle(); // cycle 21
    chk("wrap_c21_pc",   if_pc,     32'hFFFF_FFF8);
    chk("wrap_c21_addr", imem_addr, 32'h0);
    step(); settle(); // cycle 22
    chk("wrap_c22_pc",   if_pc,   32'hFFFF_FFFC);
    chk("wrap_c22_inst", if_inst, 32'hFFFF_FFFC);

    // cycle 23: reset with a request in flight
    step();
    rst = 1'b1;
    settle();
    chk("prerst_pc",  if_pc,         32'h0);
    chk("prerst_req", 32'(imem_req), 32'h1);
    step(); // cycle 24: BOOT, in-flight response arrives and is discarded
    rst = 1'b0;
    settle();
    chk("rst2_req",   32'(imem_req), 32'h0);
    chk("rst2_addr",  imem_addr,     32'h0);
    chk("rst2_valid", 32'(if_valid), 32'h0);
    chk("rst2_inst",  if_inst,       32'h0000_0013);
    chk("rst2_pc",    if_pc,         32'h0);
    step(); settle(); // cycle 25
    chk("rst2_c25_valid", 32'(if_valid), 32'h0);
    chk("rst2_c25_addr",  imem_addr,     32'h0);
    step(); settle(); // cycle 26
    chk("rst2_c26_valid", 32'(if_valid), 32'h0);
    step(); settle(); // cycle 27
    chk("rst2_c27_valid", 32'(if_valid), 32'h1);
    chk("rst2_c27_pc",    if_pc,         32'h0);
    step(); settle(); // cycle 28
    chk("rst2_c28_pc", if_pc, 32'h4);

    // cycles 29-33: id_ready low, FIFO fills and requests stop
    step();
    id_ready = 1'b0;
    settle();
    chk("bp_c29_pc",  if_pc,         32'h8);
    chk("bp_c29_req", 32'(imem_req), 32'h0);
    step(); step(); settle(); // cycle 31
    chk("bp_c31_pc",   if_pc,         32'h8);
    chk("bp_c31_inst", if_inst,       32'h8);
    chk("bp_c31_req",  32'(imem_req), 32'h0);
    step(); step(); settle(); // cycle 33
    chk("bp_c33_pc",  if_pc,         32'h8);
    chk("bp_c33_req", 32'(imem_req), 32'h0);
    step(); // cycle 34
    id_ready = 1'b1;
    settle();
    chk("bp_c34_pc",   if_pc,         32'h8);
    chk("bp_c34_req",  32'(imem_req), 32'h1);
    chk("bp_c34_addr", imem_addr,     32'h10);
    step(); settle(); // cycle 35
    chk("bp_c35_pc", if_pc, 32'hC);
    step(); settle(); // cycle 36
    chk("bp_c36_pc", if_pc, 32'h10);
    step(); settle(); // cycle 37
    chk("bp_c37_pc",   if_pc,   32'h14);
    chk("bp_c37_inst", if_inst, 32'h14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
